// File: rtl/ipsum_fifo_fill_ctrl.sv
// GLB-to-FIFO reader for input partial sums: fetches halfwords via the shared arbiter
// and pushes them into the ipsum FIFO. Define IPSUM_BURST_READ_EN for full-word bursts.
module ipsum_fifo_fill_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ipsum_fifo_reset_i,
  input  logic        ipsum_need_pop_i,
  input  logic [31:0] ipsum_pop_num_i,
  input  logic [31:0] ipsum_glb_base_addr_i,
  input  logic        ipsum_fifo_mask_i,
  input  logic        ipsum_permit_read_i,
  input  logic [31:0] ipsum_glb_read_data_i,
  input  logic        ipsum_fifo_full_i,
  input  logic        ipsum_fifo_almost_full_i,
  input  logic        ipsum_fifo_empty_i,
  input  logic        pe_array_move_i,
  output logic        ipsum_read_req_o,
  output logic [31:0] ipsum_glb_read_addr_o,
  output logic        ipsum_fifo_push_o,
  output logic [31:0] ipsum_fifo_push_data_o,
  output logic        ipsum_fifo_push_mod_o,
  output logic        ipsum_fifo_pop_o,
  output logic        ipsum_fifo_done_o
);

  // state | meaning
  // IDLE  | waiting for an L2 start, done high
  // FILL  | issuing GLB reads, at most 4 grants in a row
  // REST  | one request-free cycle so other arbiter ports get a slot
  // DONE  | all elements pushed, done high until re-armed
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REST, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_num;
  logic [31:0] r_base;
  logic [31:0] r_issue_cnt;
  logic [2:0]  r_grant_cnt;
  logic        r_inflight;
  logic        r_sel_hi;

  logic [31:0] w_read_addr;
  logic [31:0] w_issue_inc;
  logic [15:0] w_half;
  logic        w_req;
  logic        w_grant;
  logic        w_fill_exit;

`ifdef IPSUM_BURST_READ_EN
  logic        r_burst;
  logic        w_burst;
`endif

  assign w_read_addr = r_base + (r_issue_cnt << 1);
  assign w_fill_exit = (r_issue_cnt == r_num) && !r_inflight;

  // Almost-full only blocks when a push is already on its way into that last slot.
  assign w_req = (r_state == S_FILL) && (r_issue_cnt < r_num) && !ipsum_fifo_full_i &&
                 !(r_inflight && ipsum_fifo_almost_full_i) && (r_grant_cnt < 3'd4);
  assign w_grant = w_req && ipsum_permit_read_i;

`ifdef IPSUM_BURST_READ_EN
  assign w_burst     = !w_read_addr[1] && ((r_num - r_issue_cnt) >= 32'd2);
  assign w_issue_inc = w_burst ? 32'd2 : 32'd1;
`else
  assign w_issue_inc = 32'd1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_num       <= 32'd0;
      r_base      <= 32'd0;
      r_issue_cnt <= 32'd0;
      r_grant_cnt <= 3'd0;
      r_inflight  <= 1'b0;
      r_sel_hi    <= 1'b0;
`ifdef IPSUM_BURST_READ_EN
      r_burst     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (ipsum_fifo_reset_i && (r_state != S_IDLE)) begin
        r_inflight <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_inflight <= 1'b0;
            if (ipsum_need_pop_i) begin
              r_num       <= ipsum_pop_num_i;
              r_base      <= ipsum_glb_base_addr_i;
              r_issue_cnt <= 32'd0;
              r_grant_cnt <= 3'd0;
            end
          end
          S_FILL: begin
            if (w_grant) begin
              r_issue_cnt <= r_issue_cnt + w_issue_inc;
              r_grant_cnt <= r_grant_cnt + 3'd1;
              r_inflight  <= 1'b1;
              r_sel_hi    <= w_read_addr[1];
`ifdef IPSUM_BURST_READ_EN
              r_burst     <= w_burst;
`endif
            end else begin
              r_inflight <= 1'b0;
            end
          end
          S_REST: begin
            r_grant_cnt <= 3'd0;
            r_inflight  <= 1'b0;
          end
          default: r_inflight <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ipsum_need_pop_i) begin
          w_state_nxt = (ipsum_pop_num_i == 32'd0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_fill_exit) begin
          w_state_nxt = S_DONE;
        end else if (w_grant && (r_grant_cnt == 3'd3)) begin
          w_state_nxt = S_REST;
        end
      end
      S_REST:  w_state_nxt = w_fill_exit ? S_DONE : S_FILL;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (ipsum_fifo_reset_i && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign w_half = r_sel_hi ? ipsum_glb_read_data_i[31:16] : ipsum_glb_read_data_i[15:0];

  assign ipsum_read_req_o      = w_req;
  assign ipsum_glb_read_addr_o = w_read_addr;
  assign ipsum_fifo_push_o     = r_inflight;

`ifdef IPSUM_BURST_READ_EN
  assign ipsum_fifo_push_data_o = !r_inflight ? 32'd0 :
                                  (r_burst ? ipsum_glb_read_data_i : {16'd0, w_half});
  assign ipsum_fifo_push_mod_o  = r_inflight && r_burst;
`else
  assign ipsum_fifo_push_data_o = r_inflight ? {16'd0, w_half} : 32'd0;
  assign ipsum_fifo_push_mod_o  = 1'b0;
`endif

  assign ipsum_fifo_pop_o  = pe_array_move_i && ipsum_fifo_mask_i && !ipsum_fifo_empty_i &&
                             (r_state != S_IDLE);
  assign ipsum_fifo_done_o = (r_state == S_IDLE) || (r_state == S_DONE);

endmodule

// File: tb/tb_ipsum_fifo_fill_ctrl.sv
// Scoreboard bench for ipsum_fifo_fill_ctrl: grants and pushes are checked by a monitor
// against queues filled by the directed stimulus; a small FIFO and GLB model feed the DUT.
module tb_ipsum_fifo_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_reset = 1'b0;
  logic        need_pop = 1'b0;
  logic [31:0] pop_num = 32'd0;
  logic [31:0] base_addr = 32'd0;
  logic        mask = 1'b0;
  logic        permit = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        full;
  logic        almost_full;
  logic        empty;
  logic        move = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        push;
  logic [31:0] push_data;
  logic        push_mod;
  logic        pop;
  logic        done;

  int fifo_cnt = 0;
  int fifo_depth = 64;
  int fifo_init = 0;
  int fifo_clr_req = 0;
  int fifo_clr_seen = 0;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] exp_addr[$];
  logic [32:0] exp_push[$];

  assign full        = (fifo_cnt >= fifo_depth);
  assign almost_full = (fifo_cnt == fifo_depth - 1);
  assign empty       = (fifo_cnt == 0);

  ipsum_fifo_fill_ctrl dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ipsum_fifo_reset_i       (fifo_reset),
    .ipsum_need_pop_i         (need_pop),
    .ipsum_pop_num_i          (pop_num),
    .ipsum_glb_base_addr_i    (base_addr),
    .ipsum_fifo_mask_i        (mask),
    .ipsum_permit_read_i      (permit),
    .ipsum_glb_read_data_i    (rdata),
    .ipsum_fifo_full_i        (full),
    .ipsum_fifo_almost_full_i (almost_full),
    .ipsum_fifo_empty_i       (empty),
    .pe_array_move_i          (move),
    .ipsum_read_req_o         (req),
    .ipsum_glb_read_addr_o    (addr),
    .ipsum_fifo_push_o        (push),
    .ipsum_fifo_push_data_o   (push_data),
    .ipsum_fifo_push_mod_o    (push_mod),
    .ipsum_fifo_pop_o         (pop),
    .ipsum_fifo_done_o        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // GLB contents: each word holds two halfwords derived from its word address.
  function automatic logic [31:0] glb_word(input logic [31:0] a);
    logic [15:0] w;
    w = (a[31:16] ^ a[15:0]) & 16'hFFFC;
    return {w + 16'h2222, w + 16'h0011};
  endfunction

  function automatic logic [31:0] exp_half(input logic [31:0] a);
    logic [31:0] d;
    d = glb_word(a);
    return a[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
  endfunction

  // GLB: data for a grant appears one cycle later.
  initial forever begin
    logic        g;
    logic [31:0] a;
    @(negedge clk);
    g = (req === 1'b1) && permit;
    a = addr;
    @(posedge clk);
    #1;
    rdata = g ? glb_word(a) : 32'hDEAD_BEEF;
  end

  // FIFO occupancy model driving full/almost_full/empty.
  initial forever begin
    logic p;
    logic q;
    @(negedge clk);
    p = (push === 1'b1);
    q = (pop === 1'b1);
    @(posedge clk);
    #2;
    if (fifo_clr_req != fifo_clr_seen) begin
      fifo_cnt      = fifo_init;
      fifo_clr_seen = fifo_clr_req;
    end else begin
      fifo_cnt = fifo_cnt + int'(p) - int'(q);
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if ((req === 1'b1) && permit) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        $display("FAIL grant_addr: got grant at %0h, required no grant", addr);
      end else begin
        chk("grant_addr", addr, exp_addr.pop_front());
      end
    end
    if (push === 1'b1) begin
      if (exp_push.size() == 0) begin
        n_checks++;
        $display("FAIL push_word: got push %0h mod %0b, required no push", push_data, push_mod);
      end else begin
        chk("push_word", {push_mod, push_data}, exp_push.pop_front());
      end
      chk("fifo_no_overflow", fifo_cnt < fifo_depth, 1'b1);
    end
    if (full) chk("req_low_when_full", req, 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_cfg(input int depth, input int init);
    fifo_depth = depth;
    fifo_init  = init;
    fifo_clr_req++;
  endtask

  task automatic start(input logic [31:0] num, input logic [31:0] base);
    step();
    need_pop  = 1'b1;
    pop_num   = num;
    base_addr = base;
    step();
    need_pop = 1'b0;
  endtask

  task automatic rearm();
    fifo_reset = 1'b1;
    step();
    fifo_reset = 1'b0;
    step();
  endtask

  task automatic queues_drained(input string name);
    chk({name, "_addr_q"}, exp_addr.size(), 0);
    chk({name, "_push_q"}, exp_push.size(), 0);
  endtask

  initial begin
    logic [5:0]  basic_req;
    logic [5:0]  basic_done;
    logic [14:0] fair_req;
    logic [14:0] fair_done;
    logic [7:0]  bp_req;

    // Reset state
    mask = 1'b1;
    move = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_req", req, 1'b0);
    chk("rst_push", push, 1'b0);
    chk("rst_push_mod", push_mod, 1'b0);
    chk("rst_pop", pop, 1'b0);
    chk("rst_push_data", push_data, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_done", done, 1'b1);
    step();
    rst_n = 1'b1;
    move  = 1'b0;
    step();

    // num=0 goes straight to DONE; consumer pops follow the mask
    fifo_cfg(64, 3);
    step();
    need_pop = 1'b1; pop_num = 32'd0; base_addr = 32'h500; mask = 1'b1; move = 1'b1;
    @(negedge clk);
    chk("zero_pop_idle", pop, 1'b0);
    step();
    need_pop = 1'b0;
    @(negedge clk);
    chk("zero_req", req, 1'b0);
    chk("zero_done", done, 1'b1);
    chk("zero_pop_done_state", pop, 1'b1);
    step();
    mask = 1'b0;
    @(negedge clk);
    chk("cons_pop_mask0", pop, 1'b0);
    chk("zero_req_c2", req, 1'b0);
    step();
    mask = 1'b1;
    @(negedge clk);
    chk("cons_pop_mask1", pop, 1'b1);
    step();
    fifo_reset = 1'b1;
    step();
    fifo_reset = 1'b0;
    @(negedge clk);
    chk("cons_pop_after_rearm", pop, 1'b0);
    chk("cons_done_after_rearm", done, 1'b1);
    move = 1'b0;
    mask = 1'b0;
    step();

`ifdef IPSUM_BURST_READ_EN
    // Burst: two full words then one halfword
    fifo_cfg(64, 0);
    permit = 1'b1;
    exp_addr.push_back(32'h200);
    exp_addr.push_back(32'h204);
    exp_addr.push_back(32'h208);
    exp_push.push_back({1'b1, 32'h2422_0211});
    exp_push.push_back({1'b1, 32'h2426_0215});
    exp_push.push_back({1'b0, 32'h0000_0219});
    start(32'd5, 32'h200);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) break;
      step();
    end
    chk("burst_done", done, 1'b1);
    queues_drained("burst");
    rearm();
`else
    // Basic fetch: base 0x100, num 3
    basic_req  = 6'b000111;
    basic_done = 6'b100000;
    fifo_cfg(64, 0);
    permit = 1'b1;
    exp_addr.push_back(32'h100);
    exp_addr.push_back(32'h102);
    exp_addr.push_back(32'h104);
    exp_push.push_back({1'b0, 32'h0000_0111});
    exp_push.push_back({1'b0, 32'h0000_2322});
    exp_push.push_back({1'b0, 32'h0000_0115});
    start(32'd3, 32'h100);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("basic_req", req, basic_req[k]);
      chk("basic_done", done, basic_done[k]);
      step();
    end
    queues_drained("basic");
    rearm();

    // Arbiter fairness: 4 grants, 1 rest cycle, num 10
    fair_req  = 15'b000110111101111;
    fair_done = 15'b100000000000000;
    fifo_cfg(64, 0);
    permit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_addr.push_back(32'h40 + 32'(2 * i));
      exp_push.push_back({1'b0, exp_half(32'h40 + 32'(2 * i))});
    end
    start(32'd10, 32'h40);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("fair_req", req, fair_req[k]);
      chk("fair_done", done, fair_done[k]);
      step();
    end
    queues_drained("fair");
    rearm();

    // Backpressure: 2-deep FIFO, no consumer until the FIFO has sat full
    bp_req = 8'b00000011;
    fifo_cfg(2, 0);
    permit = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_addr.push_back(32'h600 + 32'(2 * i));
      exp_push.push_back({1'b0, exp_half(32'h600 + 32'(2 * i))});
    end
    start(32'd6, 32'h600);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("bp_req", req, bp_req[k]);
      step();
    end
    chk("bp_full_held", full, 1'b1);
    move = 1'b1;
    mask = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) break;
      step();
    end
    chk("bp_done", done, 1'b1);
    queues_drained("bp");
    move = 1'b0;
    mask = 1'b0;
    rearm();

    // Abort via ipsum_fifo_reset_i on the second grant
    fifo_cfg(64, 0);
    permit = 1'b1;
    exp_addr.push_back(32'h300);
    exp_addr.push_back(32'h302);
    exp_push.push_back({1'b0, 32'h0000_0311});
    start(32'd8, 32'h300);
    @(negedge clk);
    chk("abort_req_c1", req, 1'b1);
    step();
    fifo_reset = 1'b1;
    step();
    fifo_reset = 1'b0;
    @(negedge clk);
    chk("abort_push_suppressed", push, 1'b0);
    chk("abort_done", done, 1'b1);
    chk("abort_req", req, 1'b0);
    step();
    @(negedge clk);
    chk("abort_req_c4", req, 1'b0);
    queues_drained("abort");
    step();

    // Abort via synchronous rst_n on the second grant
    fifo_cfg(64, 0);
    exp_addr.push_back(32'h700);
    exp_addr.push_back(32'h702);
    exp_push.push_back({1'b0, 32'h0000_0711});
    start(32'd8, 32'h700);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstn_push_suppressed", push, 1'b0);
    chk("rstn_done", done, 1'b1);
    chk("rstn_req", req, 1'b0);
    chk("rstn_addr", addr, 32'd0);
    step();
    queues_drained("rstn");
    permit = 1'b0;
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
